// File: rtl/sm83_regfile.sv
// SM83 register file: r8 bank, W/Z temporaries, IR, F, PC and SP, plus the
// bus address/data muxing that the control sequencer drives each cycle.
package sm83_pkg;
  typedef enum logic [2:0] {
    AS_PC   = 3'd0,
    AS_GP16 = 3'd1,
    AS_SP   = 3'd2,
    AS_WZ   = 3'd3,
    AS_FF_C = 3'd4,
    AS_NONE = 3'd5
  } addr_sel_t;

  typedef struct packed {
    logic       z;
    logic       n;
    logic       h;
    logic       c;
    logic [3:0] rsvd;
  } flags_t;
endpackage

module sm83_regfile
  import sm83_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_pc,
  input  logic        inc_r16,
  input  logic        dec_r16,
  input  logic        wz_to_pc,
  input  logic        mem_to_z,
  input  logic        mem_to_w,
  input  logic        mem_to_ir,
  input  logic        mem_to_r8,
  input  logic        capture_alu_res,
  input  logic        alu_op_a_r8,
  input  logic        update_flags,
  input  logic        r8_to_mem,
  input  logic        z_to_mem,
  input  logic        pch_to_mem,
  input  logic        pcl_to_mem,
  input  logic        wz_to_r16,
  input  logic        halt,
  input  addr_sel_t   addr_sel,
  input  logic [2:0]  dst_r8,
  input  logic [2:0]  src_r8,
  input  logic [1:0]  r16_sel,
  input  logic [7:0]  alu_res,
  input  flags_t      alu_flags,
  input  logic        alu_no_wb,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_rd,
  output logic        mem_we,
  output logic [7:0]  ir,
  output flags_t      flags,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [15:0] pc,
  output logic [15:0] sp
);
  localparam logic [2:0] IDX_HL_Z = 3'd6;
  localparam logic [2:0] IDX_A    = 3'd7;

  // Slot 6 of the bank is never written; reads of index 6 are redirected to Z.
  logic [7:0]  r8_q [8];
  logic [7:0]  r8_d [8];
  logic [7:0]  w_q, w_d, z_q, z_d, ir_q, ir_d;
  logic [3:0]  f_q, f_d;
  logic [15:0] pc_q, pc_d, sp_q, sp_d;

  logic [15:0] pair_v [4];
  logic [15:0] r16_tgt, r16_new;
  logic [7:0]  r8_wval;
  logic        r8_wen;

  always_comb begin
    pair_v[0] = {r8_q[0], r8_q[1]};
    pair_v[1] = {r8_q[2], r8_q[3]};
    pair_v[2] = {r8_q[4], r8_q[5]};
    pair_v[3] = sp_q;
  end

  assign alu_a = r8_q[IDX_A];
  assign alu_b = (src_r8 == IDX_HL_Z) ? z_q : r8_q[src_r8];
  assign ir    = ir_q;
  assign pc    = pc_q;
  assign sp    = sp_q;
  assign flags = flags_t'({f_q, 4'h0});

  always_comb begin
    mem_addr = pc_q;
    case (addr_sel)
      AS_PC:   mem_addr = pc_q;
      AS_GP16: mem_addr = pair_v[r16_sel];
      AS_SP:   mem_addr = sp_q;
      AS_WZ:   mem_addr = {w_q, z_q};
      AS_FF_C: mem_addr = {8'hFF, r8_q[1]};
      default: mem_addr = pc_q;
    endcase
  end

  assign mem_rd = (mem_to_z | mem_to_w | mem_to_ir | mem_to_r8) &
                  (addr_sel != AS_NONE) & ~halt & ~rst;
  assign mem_we = (r8_to_mem | z_to_mem | pch_to_mem | pcl_to_mem) & ~halt & ~rst;

  always_comb begin
    if (pch_to_mem)      mem_wdata = pc_q[15:8];
    else if (pcl_to_mem) mem_wdata = pc_q[7:0];
    else if (z_to_mem)   mem_wdata = z_q;
    else                 mem_wdata = alu_b;
  end

  always_comb begin
    r8_d    = r8_q;
    w_d     = w_q;
    z_d     = z_q;
    ir_d    = ir_q;
    f_d     = f_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    r16_tgt = (addr_sel == AS_SP) ? sp_q : pair_v[r16_sel];
    r16_new = r16_tgt;
    r8_wen  = capture_alu_res | mem_to_r8;
    r8_wval = capture_alu_res ? alu_res : mem_rdata;

    if (!halt) begin
      if (mem_to_z) z_d = mem_rdata;
      if (mem_to_w) w_d = mem_rdata;
      if (mem_to_ir && addr_sel == AS_PC) ir_d = mem_rdata;

      if (wz_to_pc)    pc_d = {w_q, z_q};
      else if (inc_pc) pc_d = pc_q + 16'd1;

      // Inc and dec together cancel, leaving the target untouched.
      if (inc_r16 && !dec_r16)      r16_new = r16_tgt + 16'd1;
      else if (dec_r16 && !inc_r16) r16_new = r16_tgt - 16'd1;
      if (inc_r16 ^ dec_r16) begin
        if (addr_sel == AS_SP || r16_sel == 2'd3) sp_d = r16_new;
        else {r8_d[{r16_sel, 1'b0}], r8_d[{r16_sel, 1'b1}]} = r16_new;
      end

      if (r8_wen && dst_r8 != IDX_HL_Z) r8_d[dst_r8] = r8_wval;

      if (wz_to_r16) begin
        if (r16_sel == 2'd3) sp_d = {w_q, z_q};
        else {r8_d[{r16_sel, 1'b0}], r8_d[{r16_sel, 1'b1}]} = {w_q, z_q};
      end

      // A result from the ALU path wins over any r8 write landing on A.
      if (alu_op_a_r8 && !alu_no_wb) r8_d[IDX_A] = alu_res;
      if (update_flags) f_d = {alu_flags.z, alu_flags.n, alu_flags.h, alu_flags.c};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r8_q <= '{default: 8'h00};
      w_q  <= 8'h00;
      z_q  <= 8'h00;
      ir_q <= 8'h00;
      f_q  <= 4'h0;
      pc_q <= 16'h0000;
      sp_q <= 16'hFFFE;
    end else begin
      r8_q <= r8_d;
      w_q  <= w_d;
      z_q  <= z_d;
      ir_q <= ir_d;
      f_q  <= f_d;
      pc_q <= pc_d;
      sp_q <= sp_d;
    end
  end
endmodule

// File: tb/tb_sm83_regfile.sv
// Directed bench for sm83_regfile: fetch, WZ/pair moves, call push, wraps,
// writeback priorities, halt and mid-sequence reset.
module tb_sm83_regfile;
  import sm83_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        inc_pc, inc_r16, dec_r16, wz_to_pc, mem_to_z, mem_to_w, mem_to_ir;
  logic        mem_to_r8, capture_alu_res, alu_op_a_r8, update_flags, r8_to_mem;
  logic        z_to_mem, pch_to_mem, pcl_to_mem, wz_to_r16, halt;
  addr_sel_t   addr_sel;
  logic [2:0]  dst_r8, src_r8;
  logic [1:0]  r16_sel;
  logic [7:0]  alu_res;
  flags_t      alu_flags;
  logic        alu_no_wb;
  logic [7:0]  mem_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rd, mem_we;
  logic [7:0]  ir;
  flags_t      flags;
  logic [7:0]  alu_a, alu_b;
  logic [15:0] pc, sp;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sm83_regfile dut (
    .clk(clk), .rst(rst), .inc_pc(inc_pc), .inc_r16(inc_r16), .dec_r16(dec_r16),
    .wz_to_pc(wz_to_pc), .mem_to_z(mem_to_z), .mem_to_w(mem_to_w), .mem_to_ir(mem_to_ir),
    .mem_to_r8(mem_to_r8), .capture_alu_res(capture_alu_res), .alu_op_a_r8(alu_op_a_r8),
    .update_flags(update_flags), .r8_to_mem(r8_to_mem), .z_to_mem(z_to_mem),
    .pch_to_mem(pch_to_mem), .pcl_to_mem(pcl_to_mem), .wz_to_r16(wz_to_r16), .halt(halt),
    .addr_sel(addr_sel), .dst_r8(dst_r8), .src_r8(src_r8), .r16_sel(r16_sel),
    .alu_res(alu_res), .alu_flags(alu_flags), .alu_no_wb(alu_no_wb), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_we(mem_we),
    .ir(ir), .flags(flags), .alu_a(alu_a), .alu_b(alu_b), .pc(pc), .sp(sp)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    {inc_pc, inc_r16, dec_r16, wz_to_pc, mem_to_z, mem_to_w, mem_to_ir, mem_to_r8} = '0;
    {capture_alu_res, alu_op_a_r8, update_flags, r8_to_mem, z_to_mem} = '0;
    {pch_to_mem, pcl_to_mem, wz_to_r16, halt, alu_no_wb} = '0;
    addr_sel  = AS_PC;
    dst_r8    = 3'd0;
    src_r8    = 3'd0;
    r16_sel   = 2'd0;
    alu_res   = 8'h00;
    alu_flags = flags_t'(8'h00);
    mem_rdata = 8'h00;
  endtask

  // Advance one edge and settle; inputs are cleared for the next step.
  task automatic step();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic load_wz(input logic [7:0] w, input logic [7:0] z);
    mem_to_w = 1'b1; mem_rdata = w; step();
    mem_to_z = 1'b1; mem_rdata = z; step();
  endtask

  initial begin
    clr();
    rst = 1'b1;
    #3;
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_mem_rd", {15'd0, mem_rd}, 16'd0);
    chk("rst_mem_we", {15'd0, mem_we}, 16'd0);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_sp", sp, 16'hFFFE);
    chk("rst_ir", {8'h00, ir}, 16'h0000);
    chk("rst_flags", {8'h00, flags}, 16'h0000);
    chk("rst_a", {8'h00, alu_a}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Opcode fetch
    mem_to_ir = 1'b1; inc_pc = 1'b1; addr_sel = AS_PC; mem_rdata = 8'h3E;
    #1;
    chk("fetch_rd", {15'd0, mem_rd}, 16'd1);
    chk("fetch_addr", mem_addr, 16'h0000);
    step();
    chk("fetch_ir", {8'h00, ir}, 16'h003E);
    chk("fetch_pc", pc, 16'h0001);

    // IR only loads from a PC-addressed read
    mem_to_ir = 1'b1; addr_sel = AS_SP; mem_rdata = 8'h77;
    step();
    chk("ir_non_pc", {8'h00, ir}, 16'h003E);

    // WZ into HL, then wz_to_r16 beats inc_r16
    load_wz(8'h12, 8'h34);
    addr_sel = AS_WZ; #1;
    chk("wz_addr", mem_addr, 16'h1234);
    wz_to_r16 = 1'b1; r16_sel = 2'd2;
    step();
    addr_sel = AS_GP16; r16_sel = 2'd2; #1;
    chk("hl_addr", mem_addr, 16'h1234);
    src_r8 = 3'd4; #1;
    chk("alu_b_h", {8'h00, alu_b}, 16'h0012);
    src_r8 = 3'd6; #1;
    chk("alu_b_z", {8'h00, alu_b}, 16'h0034);
    inc_r16 = 1'b1; wz_to_r16 = 1'b1;
    step();
    addr_sel = AS_GP16; r16_sel = 2'd2; #1;
    chk("hl_wz_prio", mem_addr, 16'h1234);
    inc_r16 = 1'b1;
    step();
    addr_sel = AS_GP16; r16_sel = 2'd2; #1;
    chk("hl_inc", mem_addr, 16'h1235);
    inc_r16 = 1'b1; dec_r16 = 1'b1;
    step();
    addr_sel = AS_GP16; r16_sel = 2'd2; #1;
    chk("hl_incdec", mem_addr, 16'h1235);

    // Call push of 0xABCD, target 0x0200
    load_wz(8'hAB, 8'hCD);
    wz_to_pc = 1'b1; step();
    chk("pc_abcd", pc, 16'hABCD);
    load_wz(8'h02, 8'h00);
    dec_r16 = 1'b1; addr_sel = AS_SP; step();
    chk("push_sp1", sp, 16'hFFFD);
    pch_to_mem = 1'b1; dec_r16 = 1'b1; addr_sel = AS_SP; #1;
    chk("push_we_h", {15'd0, mem_we}, 16'd1);
    chk("push_addr_h", mem_addr, 16'hFFFD);
    chk("push_data_h", {8'h00, mem_wdata}, 16'h00AB);
    step();
    chk("push_sp2", sp, 16'hFFFC);
    pcl_to_mem = 1'b1; wz_to_pc = 1'b1; addr_sel = AS_SP; #1;
    chk("push_addr_l", mem_addr, 16'hFFFC);
    chk("push_data_l", {8'h00, mem_wdata}, 16'h00CD);
    step();
    chk("call_pc", pc, 16'h0200);

    // Wraps
    load_wz(8'hFF, 8'hFF);
    wz_to_pc = 1'b1; step();
    inc_pc = 1'b1; step();
    chk("pc_wrap", pc, 16'h0000);
    load_wz(8'h00, 8'h00);
    wz_to_r16 = 1'b1; r16_sel = 2'd3; step();
    chk("sp_zero", sp, 16'h0000);
    dec_r16 = 1'b1; addr_sel = AS_SP; step();
    chk("sp_wrap", sp, 16'hFFFF);

    // Writeback priorities
    capture_alu_res = 1'b1; mem_to_r8 = 1'b1; dst_r8 = 3'd7; alu_res = 8'h55; mem_rdata = 8'hAA;
    step();
    chk("a_capture", {8'h00, alu_a}, 16'h0055);
    mem_to_r8 = 1'b1; dst_r8 = 3'd1; mem_rdata = 8'h77; step();
    addr_sel = AS_FF_C; #1;
    chk("ffc_addr", mem_addr, 16'hFF77);
    alu_op_a_r8 = 1'b1; alu_no_wb = 1'b1; alu_res = 8'h99; update_flags = 1'b1;
    alu_flags = flags_t'(8'hAF);
    step();
    chk("cp_a", {8'h00, alu_a}, 16'h0055);
    chk("cp_flags", {8'h00, flags}, 16'h00A0);
    alu_op_a_r8 = 1'b1; alu_res = 8'h99; mem_to_r8 = 1'b1; dst_r8 = 3'd7; mem_rdata = 8'h11;
    step();
    chk("a_alu_prio", {8'h00, alu_a}, 16'h0099);
    capture_alu_res = 1'b1; dst_r8 = 3'd6; alu_res = 8'h42; step();
    src_r8 = 3'd6; #1;
    chk("dst6_z", {8'h00, alu_b}, 16'h0000);
    src_r8 = 3'd1; #1;
    chk("dst6_c", {8'h00, alu_b}, 16'h0077);
    chk("dst6_a", {8'h00, alu_a}, 16'h0099);
    r8_to_mem = 1'b1; src_r8 = 3'd1; #1;
    chk("r8_wdata", {8'h00, mem_wdata}, 16'h0077);
    z_to_mem = 1'b1; #1;
    chk("z_wdata", {8'h00, mem_wdata}, 16'h0000);
    clr();

    // NONE address source: no read strobe, address falls back to PC
    mem_to_z = 1'b1; addr_sel = AS_NONE; #1;
    chk("none_rd", {15'd0, mem_rd}, 16'd0);
    chk("none_addr", mem_addr, 16'h0000);
    clr();

    // Halt freezes everything
    halt = 1'b1; inc_pc = 1'b1; mem_to_ir = 1'b1; r8_to_mem = 1'b1; mem_rdata = 8'hC3; #1;
    chk("halt_rd", {15'd0, mem_rd}, 16'd0);
    chk("halt_we", {15'd0, mem_we}, 16'd0);
    step();
    chk("halt_pc", pc, 16'h0000);
    chk("halt_ir", {8'h00, ir}, 16'h003E);

    // Reset in the middle of a cycle with writes pending
    inc_pc = 1'b1; alu_op_a_r8 = 1'b1; alu_res = 8'h33;
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_pc", pc, 16'h0000);
    chk("mrst_sp", sp, 16'hFFFE);
    chk("mrst_a", {8'h00, alu_a}, 16'h0000);
    chk("mrst_flags", {8'h00, flags}, 16'h0000);
    chk("mrst_ir", {8'h00, ir}, 16'h0000);
    addr_sel = AS_WZ; #1;
    chk("mrst_wz", mem_addr, 16'h0000);
    src_r8 = 3'd1; #1;
    chk("mrst_c", {8'h00, alu_b}, 16'h0000);
    @(posedge clk); #1;
    chk("mrst_pc_hold", pc, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/sm83_regfile.md
SM83_REGFILE -- requirements
Module: sm83_regfile

Interface
REQ-001 The block SHALL have these parameters: none; all types come from sm83_pkg (addr_sel_t, flags_t).
REQ-002 The block SHALL have these clock and reset ports: clk in 1, the single clock; rst in 1, asynchronous active-high reset.
REQ-003 The block SHALL have these control inputs: inc_pc, inc_r16, dec_r16, wz_to_pc, mem_to_z, mem_to_w, mem_to_ir, mem_to_r8, capture_alu_res, alu_op_a_r8, update_flags, r8_to_mem, z_to_mem, pch_to_mem, pcl_to_mem, wz_to_r16 and halt, each in 1, each a per-cycle strobe from the control sequencer.
REQ-004 The block SHALL have these select and data inputs: addr_sel in addr_sel_t, bus address source; dst_r8 in 3, destination r8 index; src_r8 in 3, source r8 index; r16_sel in 2, 16-bit pair (0 BC, 1 DE, 2 HL, 3 SP); alu_res in 8, ALU result; alu_flags in flags_t, ALU flags; alu_no_wb in 1, suppress A writeback (CP); mem_rdata in 8, read data.
REQ-005 The block SHALL have these outputs: mem_addr out 16; mem_wdata out 8; mem_rd out 1; mem_we out 1; ir out 8; flags out flags_t; alu_a out 8, which is register A; alu_b out 8, the source operand; pc out 16; sp out 16.

Function
REQ-006 The r8 index map SHALL be 0 B, 1 C, 2 D, 3 E, 4 H, 5 L, 6 (HL)/Z, 7 A.
REQ-007 alu_b SHALL be combinational: Z when src_r8==6, otherwise r8[src_r8].
REQ-008 mem_addr SHALL be combinational per addr_sel: PC→pc; GP16→pair[r16_sel]; SP→sp; WZ→{W,Z}; FF_C→{8'hFF,C}; NONE→pc.
REQ-009 mem_rd SHALL be (mem_to_z|mem_to_w|mem_to_ir|mem_to_r8) & (addr_sel!=NONE) & !halt.
REQ-010 mem_we SHALL be (r8_to_mem|z_to_mem|pch_to_mem|pcl_to_mem) & !halt.
REQ-011 mem_wdata SHALL follow priority pch_to_mem→pc[15:8], pcl_to_mem→pc[7:0], z_to_mem→Z, else r8[src_r8], reflecting pre-edge register values.
REQ-012 On a clock edge, mem_to_z SHALL load Z and mem_to_w SHALL load W from mem_rdata.
REQ-013 On a clock edge, mem_to_ir SHALL load IR only when addr_sel==PC.
REQ-014 PC update priority SHALL be wz_to_pc (pc←{W,Z}) over inc_pc (pc←pc+1, 16-bit wrap 0xFFFF→0x0000).
REQ-015 r8 write priority SHALL be capture_alu_res (alu_res) over mem_to_r8 (mem_rdata), targeting r8[dst_r8]; dst_r8==6 SHALL write nothing.
REQ-016 alu_op_a_r8 SHALL write alu_res to A unless alu_no_wb, and SHALL take priority over an r8 write to A in the same cycle.
REQ-017 update_flags SHALL load F upper nibble from alu_flags; F[3:0] SHALL always read 0.
REQ-018 The inc_r16/dec_r16 target SHALL be SP when addr_sel==SP, else pair[r16_sel], with 16-bit wrap (0x0000-1=0xFFFF).
REQ-019 inc_r16 and dec_r16 asserted together SHALL leave the target unchanged.
REQ-020 wz_to_r16 SHALL write {W,Z} to pair[r16_sel] (W high) and SHALL take priority over inc/dec of the same pair.
REQ-021 Writes to different registers in one cycle SHALL all take effect.
REQ-022 Register writes SHALL be visible on outputs the cycle after the edge; there is no bypass.
REQ-023 When halt=1, all register updates, including PC, SHALL be frozen and mem_rd=mem_we=0.

Reset
REQ-024 While rst=1 the block SHALL asynchronously clear B,C,D,E,H,L,A,W,Z to 0x00, set F=0x00, IR=0x00 (NOP), PC=0x0000 and SP=0xFFFE.
REQ-025 Reset asserted mid-instruction SHALL take effect immediately and discard any pending writes.
REQ-026 Outputs SHALL be valid combinationally from reset values during reset: mem_addr=0x0000, mem_rd=0, mem_we=0.

Verification
REQ-027 Release reset, then pulse mem_to_ir+inc_pc with addr_sel=PC and mem_rdata=0x3E -> ir=0x3E, pc=0x0001, mem_rd=1 in that cycle.
REQ-028 Load W=0x12, Z=0x34; wz_to_r16 with r16_sel=2 -> mem_addr under GP16 = 0x1234; then inc_r16 and wz_to_r16 in the same cycle -> HL stays 0x1234.
REQ-029 Call push with pc=0xABCD, sp=0xFFFE: dec_r16 (SP) -> sp=0xFFFD; pch_to_mem+dec_r16 -> write 0xAB @0xFFFD, sp=0xFFFC; pcl_to_mem+wz_to_pc, WZ=0x0200 -> write 0xCD @0xFFFC, pc=0x0200.
REQ-030 Wrap cases: pc=0xFFFF with inc_pc -> 0x0000; sp=0x0000 with dec_r16 (addr_sel=SP) -> 0xFFFF.
REQ-031 Writeback cases: capture_alu_res and mem_to_r8 with dst_r8=7 -> A=alu_res; alu_op_a_r8 with alu_no_wb=1 -> A unchanged and F updated with F[3:0]=0; dst_r8=6 -> no register changes.
REQ-032 halt=1 with inc_pc and mem_to_ir -> pc and ir unchanged, mem_rd=0; rst pulsed mid-sequence -> all registers return to their reset values.
